// File: rtl/traffic_light_pkg.sv
// Shared types for the four-approach fixed-time junction controller:
// phase encoding, lamp codes and the phase-to-lamp decode.
package traffic_light_pkg;

  typedef enum logic [2:0] {S1, S2, S3, S4, S5, S6} phase_e;

  typedef logic [2:0] lamp_t;

  localparam lamp_t RED    = 3'b100;
  localparam lamp_t YELLOW = 3'b010;
  localparam lamp_t GREEN  = 3'b001;

  typedef struct packed {
    lamp_t m1;
    lamp_t m2;
    lamp_t mt;
    lamp_t s;
  } lamps_t;

  // Side road is green/yellow only in phases where every main lamp is red.
  function automatic lamps_t phase_lamps(input phase_e p);
    lamps_t l;
    case (p)
      S1:      l = '{m1: GREEN,  m2: GREEN,  mt: RED,    s: RED};
      S2:      l = '{m1: GREEN,  m2: YELLOW, mt: RED,    s: RED};
      S3:      l = '{m1: GREEN,  m2: RED,    mt: GREEN,  s: RED};
      S4:      l = '{m1: YELLOW, m2: RED,    mt: YELLOW, s: RED};
      S5:      l = '{m1: RED,    m2: RED,    mt: RED,    s: GREEN};
      S6:      l = '{m1: RED,    m2: RED,    mt: RED,    s: YELLOW};
      default: l = '{m1: RED,    m2: RED,    mt: RED,    s: RED};
    endcase
    return l;
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    case (p)
      S1:      n = S2;
      S2:      n = S3;
      S3:      n = S4;
      S4:      n = S5;
      S5:      n = S6;
      default: n = S1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase up-counter: counts 0..dur-1, raises done on the last cycle and
// clears itself on that edge or on reset.
module phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W:0]   dur_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // dur_i may equal 2^CNT_W, hence the extra bit on the compare.
  assign done_o = ({1'b0, cnt_q} == (dur_i - 1'b1));
  assign cnt_d  = done_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_light_controller.sv
// Six-phase Moore controller driving one-hot lamp groups for M1, M2, MT and S.
// Lamp outputs are registered alongside the phase register.
module traffic_light_controller
  import traffic_light_pkg::*;
#(
  parameter int T_MAIN = 7,
  parameter int T_TURN = 5,
  parameter int T_SIDE = 3,
  parameter int T_YEL  = 2,
  parameter int CNT_W  = 5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S
);

  localparam int DW = CNT_W + 1;
  localparam logic [CNT_W:0] D_MAIN = DW'(T_MAIN);
  localparam logic [CNT_W:0] D_TURN = DW'(T_TURN);
  localparam logic [CNT_W:0] D_SIDE = DW'(T_SIDE);
  localparam logic [CNT_W:0] D_YEL  = DW'(T_YEL);

  phase_e         state_q;
  phase_e         state_d;
  lamps_t         lamps_q;
  logic [CNT_W:0] dur;
  logic           done;

  always_comb begin
    dur = D_YEL;
    case (state_q)
      S1:      dur = D_MAIN;
      S3:      dur = D_TURN;
      S5:      dur = D_SIDE;
      default: dur = D_YEL;
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .dur_i  (dur),
    .done_o (done)
  );

  assign state_d = done ? next_phase(state_q) : state_q;

  // lamps_q always holds phase_lamps(state_q); updating both together keeps
  // the outputs glitch-free and free of any path from rst or the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S1;
      lamps_q <= phase_lamps(S1);
    end else begin
      state_q <= state_d;
      lamps_q <= phase_lamps(state_d);
    end
  end

  assign light_M1 = lamps_q.m1;
  assign light_M2 = lamps_q.m2;
  assign light_MT = lamps_q.mt;
  assign light_S  = lamps_q.s;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: three parameterisations share one reset; a schedule-based
// reference model predicts lamps from cycles elapsed since the last reset edge.
module tb_traffic_light_controller;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic clk;
  logic rst;
  logic [2:0] m1 [3];
  logic [2:0] m2 [3];
  logic [2:0] mt [3];
  logic [2:0] sl [3];

  int n_checks = 0;
  int n_fail   = 0;

  // durations per instance in phase order S1..S6
  int dur_tab [3][6] = '{'{7, 2, 5, 2, 3, 2},
                         '{1, 1, 1, 1, 1, 1},
                         '{20, 2, 5, 2, 3, 2}};

  // {M1, M2, MT, S} per phase
  logic [11:0] lamp_tab [6] = '{{G, G, R, R},
                                {G, Y, R, R},
                                {G, R, G, R},
                                {Y, R, Y, R},
                                {R, R, R, G},
                                {R, R, R, Y}};

  logic [11:0] exp_q [3][$];

  traffic_light_controller dut0 (
    .clk(clk), .rst(rst),
    .light_M1(m1[0]), .light_M2(m2[0]), .light_MT(mt[0]), .light_S(sl[0]));

  traffic_light_controller #(.T_MAIN(1), .T_TURN(1), .T_SIDE(1), .T_YEL(1), .CNT_W(5)) dut1 (
    .clk(clk), .rst(rst),
    .light_M1(m1[1]), .light_M2(m2[1]), .light_MT(mt[1]), .light_S(sl[1]));

  traffic_light_controller #(.T_MAIN(20), .CNT_W(5)) dut2 (
    .clk(clk), .rst(rst),
    .light_M1(m1[2]), .light_M2(m2[2]), .light_MT(mt[2]), .light_S(sl[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] expected_lamps(input int k, input int t);
    int period = 0;
    int p;
    for (int i = 0; i < 6; i++) period += dur_tab[k][i];
    p = t % period;
    for (int i = 0; i < 6; i++) begin
      if (p < dur_tab[k][i]) return lamp_tab[i];
      p -= dur_tab[k][i];
    end
    return 12'h000;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every output cycle pops one prediction per instance.
  initial begin
    logic [11:0] act;
    logic [11:0] req;
    bit ok;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (exp_q[k].size() > 0) begin
          req = exp_q[k].pop_front();
          act = {m1[k], m2[k], mt[k], sl[k]};
          check($sformatf("lamps_dut%0d", k), act, req);
          ok = $onehot(m1[k]) && $onehot(m2[k]) && $onehot(mt[k]) && $onehot(sl[k]);
          check($sformatf("onehot_dut%0d", k), {11'b0, ok}, 12'd1);
          ok = (sl[k] == R) || (m1[k] == R && m2[k] == R && mt[k] == R);
          check($sformatf("conflict_dut%0d", k), {11'b0, ok}, 12'd1);
        end
      end
    end
  end

  // Stimulus + reference model
  initial begin
    int  t = 0;
    bit  r;
    bit  mid_reset_done = 0;
    rst = 1'b1;
    for (int c = 0; c < 2100; c++) begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) t = 0;
      else   t++;
      for (int k = 0; k < 3; k++) exp_q[k].push_back(expected_lamps(k, t));
      if (c >= 60 && c < 120 && t == 17 && !mid_reset_done) begin
        rst = 1'b1;
        mid_reset_done = 1;
      end else if (c >= 150 && c < 155) begin
        rst = 1'b1;
      end else if (c > 300) begin
        rst = ($urandom_range(0, 199) == 0);
      end else begin
        rst = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL drain_dut%0d: %0d predictions left, required 0", k, exp_q[k].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
